// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run/debug controller:
// FSM states, halt reasons and run modes.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] R_NONE  = 2'd0;
  localparam logic [1:0] R_HALT  = 2'd1;
  localparam logic [1:0] R_BP    = 2'd2;
  localparam logic [1:0] R_LIMIT = 2'd3;

  localparam logic [1:0] M_FREE = 2'd0;
  localparam logic [1:0] M_STEP = 2'd1;
  localparam logic [1:0] M_BP   = 2'd2;

endpackage

// File: rtl/bp_match.sv
// Address breakpoint comparators with a re-arm latch so a
// resumed run does not immediately re-hit the same address.
module bp_match #(
  parameter int ADDR_W = 8,
  parameter int NUM_BP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     enable,
  input  logic                     latch,
  input  logic                     rearm,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [ADDR_W-1:0]        address,
  output logic                     hit
);

  logic              armed;
  logic              moved;
  logic [ADDR_W-1:0] last;
  logic [NUM_BP-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match[i] = bp_en[i] &&
        (address == bp_addr[i*ADDR_W +: ADDR_W]);
    end
    moved = (address != last);
    hit   = enable && (|match) && (armed || moved);
  end

  // Only executed cycles can re-arm; the address seen while
  // paused is not a sign that execution has moved on.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b1;
      last  <= '0;
    end else if (latch) begin
      armed <= 1'b0;
      last  <= address;
    end else if (rearm) begin
      armed <= 1'b1;
    end else if (run && moved) begin
      armed <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/debug controller: gates the computer with Run_En,
// stops on halt, breakpoint or cycle budget, traces each cycle.
module cpu_run_controller
  import cpu_dbg_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int IR_W       = 16,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 150,
  parameter int OPC_LSB    = 12,
  parameter logic [IR_W-OPC_LSB-1:0] HALT_OPC = 4'hF,
  parameter int NUM_BP     = 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Step,
  input  logic [1:0]               Mode,
  input  logic [NUM_BP*ADDR_W-1:0] Bp_Addr,
  input  logic [NUM_BP-1:0]        Bp_En,
  input  logic [ADDR_W-1:0]        Address,
  input  logic [IR_W-1:0]          IROut,
  output logic                     Run_En,
  output logic [2:0]               State,
  output logic [CNT_W-1:0]         Cycle_Count,
  output logic                     Done,
  output logic [1:0]               Halt_Reason,
  output logic                     Trace_Valid,
  output logic [ADDR_W-1:0]        Trace_Addr,
  output logic [IR_W-1:0]          Trace_IR
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       reason, reason_nxt;
  logic [1:0]       run_mode;
  logic             fresh, pause_entry;
  logic             halt, limit, bp_hit;

  assign Run_En      = (state == S_RUN) || (state == S_STEP);
  assign State       = state;
  assign Done        = (state == S_DONE);
  assign Cycle_Count = cnt;
  assign Halt_Reason = reason;

  assign halt  = (IROut[IR_W-1:OPC_LSB] == HALT_OPC);
  assign limit = (cnt == CNT_W'(MAX_CYCLES - 1));

  bp_match #(
    .ADDR_W (ADDR_W),
    .NUM_BP (NUM_BP)
  ) u_bp (
    .clk     (Clock),
    .rst     (Reset),
    .run     (Run_En),
    .enable  (run_mode == M_BP),
    .latch   (pause_entry),
    .rearm   (fresh),
    .bp_addr (Bp_Addr),
    .bp_en   (Bp_En),
    .address (Address),
    .hit     (bp_hit)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    reason_nxt  = reason;
    fresh       = 1'b0;
    pause_entry = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          fresh      = 1'b1;
          cnt_nxt    = '0;
          reason_nxt = R_NONE;
          if (Mode == M_STEP) begin
            state_nxt   = S_PAUSE;
            pause_entry = 1'b1;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (halt) begin
          state_nxt  = S_DONE;
          reason_nxt = R_HALT;
        end else if (bp_hit) begin
          state_nxt   = S_PAUSE;
          reason_nxt  = R_BP;
          pause_entry = 1'b1;
        end else if (limit) begin
          state_nxt  = S_DONE;
          reason_nxt = R_LIMIT;
        end
      end
      S_PAUSE: begin
        if (Start) begin
          state_nxt  = S_RUN;
          reason_nxt = R_NONE;
        end else if (Step) begin
          state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (halt) begin
          state_nxt  = S_DONE;
          reason_nxt = R_HALT;
        end else if (limit) begin
          state_nxt  = S_DONE;
          reason_nxt = R_LIMIT;
        end else begin
          state_nxt   = S_PAUSE;
          pause_entry = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      reason      <= R_NONE;
      run_mode    <= M_FREE;
      Trace_Valid <= 1'b0;
      Trace_Addr  <= '0;
      Trace_IR    <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      reason      <= reason_nxt;
      Trace_Valid <= Run_En;
      if (fresh) run_mode <= Mode;
      if (Run_En) begin
        Trace_Addr <= Address;
        Trace_IR   <= IROut;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with a small PC-like
// address model that advances on every Run_En cycle.
module tb_cpu_run_controller;

  localparam int AW   = 8;
  localparam int IW   = 16;
  localparam int CW   = 16;
  localparam int NB   = 2;
  localparam int MAXC = 10;

  logic           Clock = 1'b0;
  logic           Reset = 1'b1;
  logic           Start = 1'b0;
  logic           Step  = 1'b0;
  logic [1:0]     Mode  = 2'd0;
  logic [NB*AW-1:0] Bp_Addr = '0;
  logic [NB-1:0]  Bp_En = '0;
  logic [AW-1:0]  Address = '0;
  logic [IW-1:0]  IROut = '0;
  logic           Run_En;
  logic [2:0]     State;
  logic [CW-1:0]  Cycle_Count;
  logic           Done;
  logic [1:0]     Halt_Reason;
  logic           Trace_Valid;
  logic [AW-1:0]  Trace_Addr;
  logic [IW-1:0]  Trace_IR;

  int n_chk  = 0;
  int n_fail = 0;
  int exec_n = 0;
  int trace_n = 0;
  int halt_at = 0;
  bit ramp = 1'b1;

  cpu_run_controller #(
    .ADDR_W (AW), .IR_W (IW), .CNT_W (CW),
    .MAX_CYCLES (MAXC), .OPC_LSB (12),
    .HALT_OPC (4'hF), .NUM_BP (NB)
  ) dut (
    .Clock (Clock), .Reset (Reset), .Start (Start),
    .Step (Step), .Mode (Mode), .Bp_Addr (Bp_Addr),
    .Bp_En (Bp_En), .Address (Address), .IROut (IROut),
    .Run_En (Run_En), .State (State),
    .Cycle_Count (Cycle_Count), .Done (Done),
    .Halt_Reason (Halt_Reason), .Trace_Valid (Trace_Valid),
    .Trace_Addr (Trace_Addr), .Trace_IR (Trace_IR)
  );

  always #5 Clock = ~Clock;

  // One clock: present IR for this cycle, step, then model the
  // computer advancing its address if it was enabled.
  task automatic cyc();
    logic en;
    en = Run_En;
    if (en && halt_at == exec_n + 1) IROut = 16'hF0A5;
    else IROut = {4'h0, 4'h3, Address};
    if (en) exec_n++;
    @(posedge Clock);
    #1;
    if (Trace_Valid) trace_n++;
    if (en && ramp) Address = Address + 8'd1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    cyc();
    Start = 1'b0;
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    cyc();
    cyc();
    Reset = 1'b0;
    exec_n = 0;
    trace_n = 0;
    halt_at = 0;
    ramp = 1'b1;
    Address = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b1;
    cyc();
    cyc();
    Start = 1'b0;
    n_chk++; if (State !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", State); end
    n_chk++; if (Run_En !== 1'b0) begin n_fail++; $display("FAIL reset_run_en: got %b want 0", Run_En); end
    n_chk++; if (Cycle_Count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", Cycle_Count); end
    n_chk++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
    n_chk++; if (Halt_Reason !== 2'd0) begin n_fail++; $display("FAIL reset_reason: got %0d want 0", Halt_Reason); end
    n_chk++; if (Trace_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", Trace_Valid); end
    n_chk++; if (Trace_Addr !== 8'h00) begin n_fail++; $display("FAIL reset_taddr: got %h want 00", Trace_Addr); end
    n_chk++; if (Trace_IR !== 16'h0000) begin n_fail++; $display("FAIL reset_tir: got %h want 0000", Trace_IR); end
    Reset = 1'b0;
  endtask

  task automatic test_limit();
    apply_reset();
    Mode = 2'd0;
    pulse_start();
    for (int i = 0; i < 40 && !Done; i++) cyc();
    n_chk++; if (Done !== 1'b1) begin n_fail++; $display("FAIL limit_done: got %b want 1", Done); end
    n_chk++; if (exec_n != 10) begin n_fail++; $display("FAIL limit_run_cycles: got %0d want 10", exec_n); end
    n_chk++; if (Cycle_Count !== 16'd10) begin n_fail++; $display("FAIL limit_count: got %0d want 10", Cycle_Count); end
    n_chk++; if (Halt_Reason !== 2'd3) begin n_fail++; $display("FAIL limit_reason: got %0d want 3", Halt_Reason); end
    n_chk++; if (trace_n != 10) begin n_fail++; $display("FAIL limit_traces: got %0d want 10", trace_n); end
    n_chk++; if (State !== 3'd4) begin n_fail++; $display("FAIL limit_state: got %0d want 4", State); end
    n_chk++; if (Trace_Addr !== 8'h09) begin n_fail++; $display("FAIL limit_taddr: got %h want 09", Trace_Addr); end
    n_chk++; if (Trace_IR !== 16'h0309) begin n_fail++; $display("FAIL limit_tir: got %h want 0309", Trace_IR); end
    cyc();
    n_chk++; if (Trace_Valid !== 1'b0) begin n_fail++; $display("FAIL limit_tvalid_after: got %b want 0", Trace_Valid); end
    n_chk++; if (Trace_Addr !== 8'h09) begin n_fail++; $display("FAIL limit_taddr_hold: got %h want 09", Trace_Addr); end
    n_chk++; if (Cycle_Count !== 16'd10) begin n_fail++; $display("FAIL limit_count_hold: got %0d want 10", Cycle_Count); end
  endtask

  task automatic test_halt();
    apply_reset();
    Mode = 2'd0;
    halt_at = 4;
    pulse_start();
    for (int i = 0; i < 40 && !Done; i++) cyc();
    n_chk++; if (Done !== 1'b1) begin n_fail++; $display("FAIL halt_done: got %b want 1", Done); end
    n_chk++; if (Cycle_Count !== 16'd4) begin n_fail++; $display("FAIL halt_count: got %0d want 4", Cycle_Count); end
    n_chk++; if (Halt_Reason !== 2'd1) begin n_fail++; $display("FAIL halt_reason: got %0d want 1", Halt_Reason); end
    n_chk++; if (trace_n != 4) begin n_fail++; $display("FAIL halt_traces: got %0d want 4", trace_n); end
    n_chk++; if (Trace_IR !== 16'hF0A5) begin n_fail++; $display("FAIL halt_tir: got %h want f0a5", Trace_IR); end
    n_chk++; if (Trace_Addr !== 8'h03) begin n_fail++; $display("FAIL halt_taddr: got %h want 03", Trace_Addr); end
  endtask

  task automatic test_step();
    apply_reset();
    Mode = 2'd1;
    pulse_start();
    n_chk++; if (State !== 3'd2) begin n_fail++; $display("FAIL step_enter_pause: got %0d want 2", State); end
    n_chk++; if (Run_En !== 1'b0) begin n_fail++; $display("FAIL step_pause_run_en: got %b want 0", Run_En); end
    for (int k = 0; k < 3; k++) begin
      Step = 1'b1;
      cyc();
      Step = 1'b0;
      repeat (4) cyc();
    end
    n_chk++; if (exec_n != 3) begin n_fail++; $display("FAIL step_run_cycles: got %0d want 3", exec_n); end
    n_chk++; if (Cycle_Count !== 16'd3) begin n_fail++; $display("FAIL step_count: got %0d want 3", Cycle_Count); end
    n_chk++; if (State !== 3'd2) begin n_fail++; $display("FAIL step_state: got %0d want 2", State); end
    n_chk++; if (trace_n != 3) begin n_fail++; $display("FAIL step_traces: got %0d want 3", trace_n); end
    n_chk++; if (Trace_Addr !== 8'h02) begin n_fail++; $display("FAIL step_taddr: got %h want 02", Trace_Addr); end
  endtask

  task automatic test_breakpoint();
    apply_reset();
    Mode = 2'd2;
    Bp_Addr = {8'h03, 8'h05};
    Bp_En = 2'b01;
    pulse_start();
    for (int i = 0; i < 30 && State !== 3'd2; i++) cyc();
    n_chk++; if (State !== 3'd2) begin n_fail++; $display("FAIL bp_state: got %0d want 2", State); end
    n_chk++; if (Halt_Reason !== 2'd2) begin n_fail++; $display("FAIL bp_reason: got %0d want 2", Halt_Reason); end
    n_chk++; if (Cycle_Count !== 16'd6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", Cycle_Count); end
    n_chk++; if (Trace_Addr !== 8'h05) begin n_fail++; $display("FAIL bp_taddr: got %h want 05", Trace_Addr); end
    Address = 8'h05;
    cyc();
    cyc();
    pulse_start();
    n_chk++; if (State !== 3'd1) begin n_fail++; $display("FAIL bp_resume_state: got %0d want 1", State); end
    n_chk++; if (Halt_Reason !== 2'd0) begin n_fail++; $display("FAIL bp_resume_reason: got %0d want 0", Halt_Reason); end
    for (int i = 0; i < 30 && !Done; i++) cyc();
    n_chk++; if (Done !== 1'b1) begin n_fail++; $display("FAIL bp_final_done: got %b want 1", Done); end
    n_chk++; if (Halt_Reason !== 2'd3) begin n_fail++; $display("FAIL bp_final_reason: got %0d want 3", Halt_Reason); end
    n_chk++; if (Cycle_Count !== 16'd10) begin n_fail++; $display("FAIL bp_final_count: got %0d want 10", Cycle_Count); end
    n_chk++; if (Trace_Addr !== 8'h08) begin n_fail++; $display("FAIL bp_final_taddr: got %h want 08", Trace_Addr); end
    Bp_En = '0;
  endtask

  task automatic test_halt_limit();
    apply_reset();
    Mode = 2'd0;
    halt_at = 10;
    pulse_start();
    for (int i = 0; i < 40 && !Done; i++) cyc();
    n_chk++; if (Halt_Reason !== 2'd1) begin n_fail++; $display("FAIL hl_reason: got %0d want 1", Halt_Reason); end
    n_chk++; if (Cycle_Count !== 16'd10) begin n_fail++; $display("FAIL hl_count: got %0d want 10", Cycle_Count); end
  endtask

  task automatic test_start_step();
    apply_reset();
    Mode = 2'd1;
    pulse_start();
    Start = 1'b1;
    Step = 1'b1;
    cyc();
    Start = 1'b0;
    Step = 1'b0;
    n_chk++; if (State !== 3'd1) begin n_fail++; $display("FAIL ss_state: got %0d want 1", State); end
    n_chk++; if (Run_En !== 1'b1) begin n_fail++; $display("FAIL ss_run_en: got %b want 1", Run_En); end
    Step = 1'b1;
    cyc();
    Step = 1'b0;
    n_chk++; if (State !== 3'd1) begin n_fail++; $display("FAIL ss_step_ignored: got %0d want 1", State); end
    pulse_start();
    n_chk++; if (Cycle_Count !== 16'd2) begin n_fail++; $display("FAIL ss_start_ignored: got %0d want 2", Cycle_Count); end
    for (int i = 0; i < 30 && !Done; i++) cyc();
    n_chk++; if (Halt_Reason !== 2'd3) begin n_fail++; $display("FAIL ss_reason: got %0d want 3", Halt_Reason); end
    n_chk++; if (exec_n != 10) begin n_fail++; $display("FAIL ss_run_cycles: got %0d want 10", exec_n); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    Mode = 2'd0;
    pulse_start();
    for (int i = 0; i < 20 && Cycle_Count !== 16'd6; i++) cyc();
    n_chk++; if (Run_En !== 1'b1) begin n_fail++; $display("FAIL mr_running: got %b want 1", Run_En); end
    Reset = 1'b1;
    cyc();
    n_chk++; if (State !== 3'd0) begin n_fail++; $display("FAIL mr_state: got %0d want 0", State); end
    n_chk++; if (Run_En !== 1'b0) begin n_fail++; $display("FAIL mr_run_en: got %b want 0", Run_En); end
    n_chk++; if (Cycle_Count !== 16'd0) begin n_fail++; $display("FAIL mr_count: got %0d want 0", Cycle_Count); end
    n_chk++; if (Trace_Valid !== 1'b0) begin n_fail++; $display("FAIL mr_tvalid: got %b want 0", Trace_Valid); end
    n_chk++; if (Trace_Addr !== 8'h00) begin n_fail++; $display("FAIL mr_taddr: got %h want 00", Trace_Addr); end
    n_chk++; if (Trace_IR !== 16'h0000) begin n_fail++; $display("FAIL mr_tir: got %h want 0000", Trace_IR); end
    Reset = 1'b0;
    pulse_start();
    n_chk++; if (State !== 3'd1) begin n_fail++; $display("FAIL mr_restart_state: got %0d want 1", State); end
    n_chk++; if (Cycle_Count !== 16'd0) begin n_fail++; $display("FAIL mr_restart_count: got %0d want 0", Cycle_Count); end
    cyc();
    n_chk++; if (Cycle_Count !== 16'd1) begin n_fail++; $display("FAIL mr_restart_count1: got %0d want 1", Cycle_Count); end
  endtask

  initial begin
    test_reset();
    test_limit();
    test_halt();
    test_step();
    test_breakpoint();
    test_halt_limit();
    test_start_step();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
